// File: rtl/total_zeros_stream_enc_if.sv
// Coefficient-in / codeword-out handshake bundle of the CAVLC total_zeros encoder.
// The master is the upstream/downstream side; the slave is the encoder.
interface total_zeros_stream_enc_if #(
    parameter int COEF_W = 16,
    parameter int CODE_W = 9
);
    logic [1:0]        blk_mode;
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] in_coef;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic [3:0]        out_len;
    logic [4:0]        out_total_coeff;
    logic [3:0]        out_total_zeros;
    logic              out_err;

    modport master (
        output blk_mode, in_valid, in_coef, in_last, out_ready,
        input  in_ready, out_valid, out_code, out_len, out_total_coeff, out_total_zeros, out_err
    );

    modport slave (
        input  blk_mode, in_valid, in_coef, in_last, out_ready,
        output in_ready, out_valid, out_code, out_len, out_total_coeff, out_total_zeros, out_err
    );
endinterface

// File: rtl/total_zeros_stream_enc.sv
// Streaming CAVLC total_zeros encoder: counts TotalCoeff/TotalZeros over a zig-zag coefficient
// stream and emits the right-aligned total_zeros codeword with its length.
module total_zeros_stream_enc #(
    parameter int COEF_W = 16,
    parameter int CODE_W = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    total_zeros_stream_enc_if.slave bus
);
    typedef enum logic [1:0] {COLLECT = 2'd0, LOOKUP = 2'd1, HOLD = 2'd2} state_t;

    // Table entries are {len[3:0], code[8:0]}, keyed by {TotalCoeff[3:0], total_zeros[3:0]}.
    function automatic logic [12:0] tz_vlc_4x4(input logic [3:0] tc, input logic [3:0] tz);
        logic [12:0] r;
        r = 13'd0;
        case ({tc, tz})
            8'h10: r = {4'd1, 9'b1};      8'h11: r = {4'd3, 9'b011};    8'h12: r = {4'd3, 9'b010};
            8'h13: r = {4'd4, 9'b0011};   8'h14: r = {4'd4, 9'b0010};   8'h15: r = {4'd5, 9'b00011};
            8'h16: r = {4'd5, 9'b00010};  8'h17: r = {4'd6, 9'b000011}; 8'h18: r = {4'd6, 9'b000010};
            8'h19: r = {4'd7, 9'b0000011};  8'h1a: r = {4'd7, 9'b0000010};
            8'h1b: r = {4'd8, 9'b00000011}; 8'h1c: r = {4'd8, 9'b00000010};
            8'h1d: r = {4'd9, 9'b000000011}; 8'h1e: r = {4'd9, 9'b000000010};
            8'h1f: r = {4'd9, 9'b000000001};
            8'h20: r = {4'd3, 9'b111};    8'h21: r = {4'd3, 9'b110};    8'h22: r = {4'd3, 9'b101};
            8'h23: r = {4'd3, 9'b100};    8'h24: r = {4'd3, 9'b011};    8'h25: r = {4'd4, 9'b0101};
            8'h26: r = {4'd4, 9'b0100};   8'h27: r = {4'd4, 9'b0011};   8'h28: r = {4'd4, 9'b0010};
            8'h29: r = {4'd5, 9'b00011};  8'h2a: r = {4'd5, 9'b00010};  8'h2b: r = {4'd6, 9'b000011};
            8'h2c: r = {4'd6, 9'b000010}; 8'h2d: r = {4'd6, 9'b000001}; 8'h2e: r = {4'd6, 9'b000000};
            8'h30: r = {4'd4, 9'b0101};   8'h31: r = {4'd3, 9'b111};    8'h32: r = {4'd3, 9'b110};
            8'h33: r = {4'd3, 9'b101};    8'h34: r = {4'd4, 9'b0100};   8'h35: r = {4'd4, 9'b0011};
            8'h36: r = {4'd3, 9'b100};    8'h37: r = {4'd3, 9'b011};    8'h38: r = {4'd4, 9'b0010};
            8'h39: r = {4'd5, 9'b00011};  8'h3a: r = {4'd5, 9'b00010};  8'h3b: r = {4'd6, 9'b000001};
            8'h3c: r = {4'd5, 9'b00001};  8'h3d: r = {4'd6, 9'b000000};
            8'h40: r = {4'd5, 9'b00011};  8'h41: r = {4'd3, 9'b111};    8'h42: r = {4'd4, 9'b0101};
            8'h43: r = {4'd4, 9'b0100};   8'h44: r = {4'd3, 9'b110};    8'h45: r = {4'd3, 9'b101};
            8'h46: r = {4'd3, 9'b100};    8'h47: r = {4'd4, 9'b0011};   8'h48: r = {4'd3, 9'b011};
            8'h49: r = {4'd4, 9'b0010};   8'h4a: r = {4'd5, 9'b00010};  8'h4b: r = {4'd5, 9'b00001};
            8'h4c: r = {4'd5, 9'b00000};
            8'h50: r = {4'd4, 9'b0101};   8'h51: r = {4'd4, 9'b0100};   8'h52: r = {4'd4, 9'b0011};
            8'h53: r = {4'd3, 9'b111};    8'h54: r = {4'd3, 9'b110};    8'h55: r = {4'd3, 9'b101};
            8'h56: r = {4'd3, 9'b100};    8'h57: r = {4'd3, 9'b011};    8'h58: r = {4'd4, 9'b0010};
            8'h59: r = {4'd5, 9'b00001};  8'h5a: r = {4'd4, 9'b0001};   8'h5b: r = {4'd5, 9'b00000};
            8'h60: r = {4'd6, 9'b000001}; 8'h61: r = {4'd5, 9'b00001};  8'h62: r = {4'd3, 9'b111};
            8'h63: r = {4'd3, 9'b110};    8'h64: r = {4'd3, 9'b101};    8'h65: r = {4'd3, 9'b100};
            8'h66: r = {4'd3, 9'b011};    8'h67: r = {4'd3, 9'b010};    8'h68: r = {4'd4, 9'b0001};
            8'h69: r = {4'd3, 9'b001};    8'h6a: r = {4'd6, 9'b000000};
            8'h70: r = {4'd6, 9'b000001}; 8'h71: r = {4'd5, 9'b00001};  8'h72: r = {4'd3, 9'b101};
            8'h73: r = {4'd3, 9'b100};    8'h74: r = {4'd3, 9'b011};    8'h75: r = {4'd2, 9'b11};
            8'h76: r = {4'd3, 9'b010};    8'h77: r = {4'd4, 9'b0001};   8'h78: r = {4'd3, 9'b001};
            8'h79: r = {4'd6, 9'b000000};
            8'h80: r = {4'd6, 9'b000001}; 8'h81: r = {4'd4, 9'b0001};   8'h82: r = {4'd5, 9'b00001};
            8'h83: r = {4'd3, 9'b011};    8'h84: r = {4'd2, 9'b11};     8'h85: r = {4'd2, 9'b10};
            8'h86: r = {4'd3, 9'b010};    8'h87: r = {4'd3, 9'b001};    8'h88: r = {4'd6, 9'b000000};
            8'h90: r = {4'd6, 9'b000001}; 8'h91: r = {4'd6, 9'b000000}; 8'h92: r = {4'd4, 9'b0001};
            8'h93: r = {4'd2, 9'b11};     8'h94: r = {4'd2, 9'b10};     8'h95: r = {4'd3, 9'b001};
            8'h96: r = {4'd2, 9'b01};     8'h97: r = {4'd5, 9'b00001};
            8'ha0: r = {4'd5, 9'b00001};  8'ha1: r = {4'd5, 9'b00000};  8'ha2: r = {4'd3, 9'b001};
            8'ha3: r = {4'd2, 9'b11};     8'ha4: r = {4'd2, 9'b10};     8'ha5: r = {4'd2, 9'b01};
            8'ha6: r = {4'd4, 9'b0001};
            8'hb0: r = {4'd4, 9'b0000};   8'hb1: r = {4'd4, 9'b0001};   8'hb2: r = {4'd3, 9'b001};
            8'hb3: r = {4'd3, 9'b010};    8'hb4: r = {4'd1, 9'b1};      8'hb5: r = {4'd3, 9'b011};
            8'hc0: r = {4'd4, 9'b0000};   8'hc1: r = {4'd4, 9'b0001};   8'hc2: r = {4'd2, 9'b01};
            8'hc3: r = {4'd1, 9'b1};      8'hc4: r = {4'd3, 9'b001};
            8'hd0: r = {4'd3, 9'b000};    8'hd1: r = {4'd3, 9'b001};    8'hd2: r = {4'd1, 9'b1};
            8'hd3: r = {4'd2, 9'b01};
            8'he0: r = {4'd2, 9'b00};     8'he1: r = {4'd2, 9'b01};     8'he2: r = {4'd1, 9'b1};
            8'hf0: r = {4'd1, 9'b0};      8'hf1: r = {4'd1, 9'b1};
            default: r = 13'd0;
        endcase
        return r;
    endfunction

    function automatic logic [12:0] tz_vlc_2x2(input logic [3:0] tc, input logic [3:0] tz);
        logic [12:0] r;
        r = 13'd0;
        case ({tc, tz})
            8'h10: r = {4'd1, 9'b1};   8'h11: r = {4'd2, 9'b01};  8'h12: r = {4'd3, 9'b001};
            8'h13: r = {4'd3, 9'b000};
            8'h20: r = {4'd1, 9'b1};   8'h21: r = {4'd2, 9'b01};  8'h22: r = {4'd2, 9'b00};
            8'h30: r = {4'd1, 9'b1};   8'h31: r = {4'd1, 9'b0};
            default: r = 13'd0;
        endcase
        return r;
    endfunction

    state_t            state_r;
    logic [4:0]        idx_r;
    logic [1:0]        mode_r;
    logic [4:0]        tc_r;
    logic [3:0]        tz_r;
    logic [3:0]        zpend_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [CODE_W-1:0] out_code_r;
    logic [3:0]        out_len_r;
    logic [4:0]        out_tc_r;
    logic [3:0]        out_tz_r;
    logic              out_err_r;
    logic              err_r;

    logic [1:0]  mode_s;
    logic [4:0]  last_idx_s;
    logic        accept_s;
    logic        nz_s;
    logic        close_s;
    logic        err_nx_s;
    logic [4:0]  tc_nx_s;
    logic [3:0]  tz_nx_s;
    logic [3:0]  zpend_nx_s;
    logic [4:0]  blk_n_s;
    logic [12:0] vlc_s;

    // Per-beat counter update; the first beat of a block supplies the mode.
    always_comb begin
        mode_s = (idx_r == 5'd0) ? bus.blk_mode : mode_r;
        case (mode_s)
            2'b01:   last_idx_s = 5'd14;
            2'b10:   last_idx_s = 5'd3;
            default: last_idx_s = 5'd15;
        endcase
        accept_s   = bus.in_valid && in_ready_r && (state_r == COLLECT);
        nz_s       = (bus.in_coef != {COEF_W{1'b0}});
        close_s    = bus.in_last || (idx_r == last_idx_s);
        err_nx_s   = (mode_s == 2'b11) || (idx_r != last_idx_s) || !bus.in_last;
        tc_nx_s    = (nz_s && (tc_r != 5'd16)) ? tc_r + 5'd1 : tc_r;
        tz_nx_s    = nz_s ? tz_r + zpend_r : tz_r;
        zpend_nx_s = nz_s ? 4'd0 : zpend_r + 4'd1;
    end

    // Codeword selection; nothing is coded for an empty or completely full block.
    always_comb begin
        case (mode_r)
            2'b01:   blk_n_s = 5'd15;
            2'b10:   blk_n_s = 5'd4;
            default: blk_n_s = 5'd16;
        endcase
        if ((tc_r == 5'd0) || (tc_r == blk_n_s)) begin
            vlc_s = 13'd0;
        end else if (mode_r == 2'b10) begin
            vlc_s = tz_vlc_2x2(tc_r[3:0], tz_r);
        end else begin
            vlc_s = tz_vlc_4x4(tc_r[3:0], tz_r);
        end
    end

    // Block FSM: collect beats, register the table lookup, hold until the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= COLLECT;
            idx_r       <= 5'd0;
            mode_r      <= 2'b00;
            tc_r        <= 5'd0;
            tz_r        <= 4'd0;
            zpend_r     <= 4'd0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_code_r  <= {CODE_W{1'b0}};
            out_len_r   <= 4'd0;
            out_tc_r    <= 5'd0;
            out_tz_r    <= 4'd0;
            out_err_r   <= 1'b0;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (accept_s) begin
                        mode_r  <= mode_s;
                        tc_r    <= tc_nx_s;
                        tz_r    <= tz_nx_s;
                        zpend_r <= zpend_nx_s;
                        if (close_s) begin
                            err_r      <= err_nx_s;
                            idx_r      <= 5'd0;
                            in_ready_r <= 1'b0;
                            state_r    <= LOOKUP;
                        end else begin
                            idx_r <= idx_r + 5'd1;
                        end
                    end
                end
                LOOKUP: begin
                    out_valid_r <= 1'b1;
                    out_code_r  <= CODE_W'(vlc_s[8:0]);
                    out_len_r   <= vlc_s[12:9];
                    out_tc_r    <= tc_r;
                    out_tz_r    <= tz_r;
                    out_err_r   <= err_r;
                    state_r     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        tc_r        <= 5'd0;
                        tz_r        <= 4'd0;
                        zpend_r     <= 4'd0;
                        err_r       <= 1'b0;
                        idx_r       <= 5'd0;
                        state_r     <= COLLECT;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    idx_r       <= 5'd0;
                    state_r     <= COLLECT;
                end
            endcase
        end
    end

    assign bus.in_ready        = in_ready_r;
    assign bus.out_valid       = out_valid_r;
    assign bus.out_code        = out_code_r;
    assign bus.out_len         = out_len_r;
    assign bus.out_total_coeff = out_tc_r;
    assign bus.out_total_zeros = out_tz_r;
    assign bus.out_err         = out_err_r;
endmodule

// File: tb/tb_total_zeros_stream_enc.sv
// Directed bench for total_zeros_stream_enc: a block-level model built from the codeword
// strings predicts each result, and a per-cycle monitor compares the DUT against it.
module tb_total_zeros_stream_enc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    total_zeros_stream_enc_if #(.COEF_W(16), .CODE_W(9)) bus ();
    total_zeros_stream_enc #(.COEF_W(16), .CODE_W(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int len;
        int tc;
        int tz;
        int err;
    } exp_t;

    exp_t               expq[$];
    int                 total = 0;
    int                 bad = 0;
    int                 cyc = 0;
    int                 due = -1;
    bit                 tb_close = 1'b0;
    logic signed [15:0] coefs[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Codewords as bit strings, one space-separated row per TotalCoeff, indexed by total_zeros.
    function automatic string tz_row(input bit chroma, input int tc);
        if (chroma) begin
            case (tc)
                1: return "1 01 001 000";
                2: return "1 01 00";
                3: return "1 0";
                default: return "";
            endcase
        end
        case (tc)
            1:  return "1 011 010 0011 0010 00011 00010 000011 000010 0000011 0000010 00000011 00000010 000000011 000000010 000000001";
            2:  return "111 110 101 100 011 0101 0100 0011 0010 00011 00010 000011 000010 000001 000000";
            3:  return "0101 111 110 101 0100 0011 100 011 0010 00011 00010 000001 00001 000000";
            4:  return "00011 111 0101 0100 110 101 100 0011 011 0010 00010 00001 00000";
            5:  return "0101 0100 0011 111 110 101 100 011 0010 00001 0001 00000";
            6:  return "000001 00001 111 110 101 100 011 010 0001 001 000000";
            7:  return "000001 00001 101 100 011 11 010 0001 001 000000";
            8:  return "000001 0001 00001 011 11 10 010 001 000000";
            9:  return "000001 000000 0001 11 10 001 01 00001";
            10: return "00001 00000 001 11 10 01 0001";
            11: return "0000 0001 001 010 1 011";
            12: return "0000 0001 01 1 001";
            13: return "000 001 1 01";
            14: return "00 01 1";
            15: return "0 1";
            default: return "";
        endcase
    endfunction

    // Expected result of the block in coefs[] given the mode and in_last position (-1 = none).
    function automatic exp_t model(input logic [1:0] mode, input int last_pos);
        exp_t  e;
        int    n;
        int    ci;
        int    lnz;
        int    tok;
        string row;
        byte   c;
        n  = (mode == 2'b10) ? 4 : (mode == 2'b01) ? 15 : 16;
        ci = (last_pos < 0 || last_pos >= n) ? n - 1 : last_pos;
        e.tc = 0;
        lnz  = -1;
        for (int i = 0; i <= ci; i++) begin
            if (coefs[i] != 16'sd0) begin
                e.tc++;
                lnz = i;
            end
        end
        e.tz   = (e.tc == 0) ? 0 : lnz + 1 - e.tc;
        e.err  = (mode == 2'b11 || last_pos != n - 1) ? 1 : 0;
        e.len  = 0;
        e.code = 0;
        if (e.tc != 0 && e.tc != n) begin
            row = tz_row(mode == 2'b10, e.tc);
            tok = 0;
            for (int i = 0; i < row.len(); i++) begin
                c = row[i];
                if (c == 8'h20) tok++;
                else if (tok == e.tz) begin
                    e.len++;
                    e.code = e.code * 2 + ((c == 8'h31) ? 1 : 0);
                end
            end
        end
        return e;
    endfunction

    // Drive one beat and wait (bounded) until it is accepted.
    task automatic drive_beat(input logic [1:0] mode, input logic signed [15:0] coef,
                              input bit last, input bit close, output bit ok);
        int w;
        bus.blk_mode = mode;
        bus.in_valid = 1'b1;
        bus.in_coef  = coef;
        bus.in_last  = last;
        tb_close     = close;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        ok = bus.in_ready;
        if (!ok) chk("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tb_close     = 1'b0;
    endtask

    task automatic send_block(input logic [1:0] mode, input int last_pos);
        int n;
        int ci;
        bit ok;
        n  = (mode == 2'b10) ? 4 : (mode == 2'b01) ? 15 : 16;
        ci = (last_pos < 0 || last_pos >= n) ? n - 1 : last_pos;
        expq.push_back(model(mode, last_pos));
        for (int i = 0; i <= ci; i++) begin
            // blk_mode is deliberately disturbed after the first beat
            drive_beat((i == 0) ? mode : ~mode, coefs[i], i == last_pos, i == ci, ok);
            if (!ok) break;
        end
    endtask

    task automatic clear_coefs();
        for (int i = 0; i < 16; i++) coefs[i] = 16'sd0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (expq.size() != 0 && w < 400) begin
            @(posedge clk);
            w++;
        end
        chk("drain_pending", expq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_out_code"}, int'(bus.out_code), 0);
        chk({tag, "_out_len"}, int'(bus.out_len), 0);
        chk({tag, "_out_tc"}, int'(bus.out_total_coeff), 0);
        chk({tag, "_out_tz"}, int'(bus.out_total_zeros), 0);
        chk({tag, "_out_err"}, int'(bus.out_err), 0);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
    endtask

    // Per-cycle monitor: result fields, hold behaviour, latency and ready after handshake.
    initial begin : compare
        bit   prev_v = 1'b0;
        bit   prev_hs = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v  = 1'b0;
                prev_hs = 1'b0;
                due     = -1;
            end else begin
                if (prev_hs) chk("in_ready_after_hs", int'(bus.in_ready), 1);
                prev_hs = 1'b0;
                if (bus.out_valid) begin
                    if (!prev_v) chk("latency_cycle", cyc, due);
                    chk("in_ready_low_in_hold", int'(bus.in_ready), 0);
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
                    end else begin
                        e = expq[0];
                        chk("out_code", int'(bus.out_code), e.code);
                        chk("out_len", int'(bus.out_len), e.len);
                        chk("out_total_coeff", int'(bus.out_total_coeff), e.tc);
                        chk("out_total_zeros", int'(bus.out_total_zeros), e.tz);
                        chk("out_err", int'(bus.out_err), e.err);
                        if (bus.out_ready) begin
                            void'(expq.pop_front());
                            prev_hs = 1'b1;
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready && tb_close) due = cyc + 2;
                prev_v = bus.out_valid;
            end
        end
    end

    initial begin : stim
        exp_t e;
        bit   ok;
        bus.blk_mode  = 2'b00;
        bus.in_valid  = 1'b0;
        bus.in_coef   = 16'sd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        clear_coefs();
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle_outputs("post_reset");

        // Block 3,0,0,1 then zeros
        clear_coefs();
        coefs[0] = 16'sd3;
        coefs[3] = 16'sd1;
        e = model(2'b00, 15);
        chk("pin1_code", e.code, 5);
        chk("pin1_len", e.len, 3);
        chk("pin1_tc", e.tc, 2);
        chk("pin1_tz", e.tz, 2);
        send_block(2'b00, 15);

        // Single coefficient in the last position: longest code
        clear_coefs();
        coefs[15] = 16'sd5;
        e = model(2'b00, 15);
        chk("pin2_code", e.code, 1);
        chk("pin2_len", e.len, 9);
        chk("pin2_tz", e.tz, 15);
        send_block(2'b00, 15);

        // Chroma DC 0,0,0,-2 and fully populated chroma DC
        clear_coefs();
        coefs[3] = -16'sd2;
        e = model(2'b10, 3);
        chk("pin3_code", e.code, 0);
        chk("pin3_len", e.len, 3);
        chk("pin3_tz", e.tz, 3);
        send_block(2'b10, 3);
        coefs[0] = 16'sd1; coefs[1] = 16'sd2; coefs[2] = -16'sd3; coefs[3] = 16'sd4;
        e = model(2'b10, 3);
        chk("pin4_len", e.len, 0);
        chk("pin4_tc", e.tc, 4);
        send_block(2'b10, 3);

        // All zeros, then an early in_last on beat 8
        clear_coefs();
        send_block(2'b00, 15);
        coefs[0] = 16'sd1; coefs[2] = 16'sd2; coefs[5] = -16'sd1;
        e = model(2'b00, 7);
        chk("pin5_err", e.err, 1);
        chk("pin5_code", e.code, 5);
        chk("pin5_len", e.len, 3);
        send_block(2'b00, 7);

        // No in_last at all, reserved mode, full 16 and full 15 blocks
        clear_coefs();
        coefs[4] = 16'sd9;
        send_block(2'b00, -1);
        coefs[1] = -16'sd7;
        send_block(2'b11, 15);
        for (int i = 0; i < 16; i++) coefs[i] = 16'(i + 1);
        send_block(2'b00, 15);
        send_block(2'b01, 14);
        coefs[0] = 16'sd0;
        send_block(2'b01, 14);

        // Backpressure: result held for 5 cycles, next block follows the handshake
        wait_drain();
        bus.out_ready = 1'b0;
        clear_coefs();
        coefs[1] = 16'sd4; coefs[6] = -16'sd3; coefs[9] = 16'sd2;
        send_block(2'b01, 14);
        begin
            int w;
            w = 0;
            while (!bus.out_valid && w < 50) begin
                @(posedge clk);
                #1;
                w++;
            end
            chk("bp_out_valid_seen", int'(bus.out_valid), 1);
        end
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        coefs[12] = 16'sd1;
        send_block(2'b00, 15);

        // Whole 4x4 and chroma DC tables
        for (int tc = 1; tc <= 15; tc++) begin
            for (int tz = 0; tz <= 16 - tc; tz++) begin
                clear_coefs();
                for (int j = 0; j < tc; j++) coefs[tz + j] = (j % 2 == 1) ? 16'(-(j + 1)) : 16'(j + 1);
                send_block(2'b00, 15);
            end
        end
        for (int tc = 1; tc <= 3; tc++) begin
            for (int tz = 0; tz <= 4 - tc; tz++) begin
                clear_coefs();
                for (int j = 0; j < tc; j++) coefs[tz + j] = -16'sd1;
                send_block(2'b10, 3);
            end
        end

        // Reset while the seventh beat of a block is on the bus
        wait_drain();
        for (int i = 0; i < 16; i++) coefs[i] = 16'(i + 1);
        for (int i = 0; i < 6; i++) drive_beat(2'b00, coefs[i], 1'b0, 1'b0, ok);
        bus.blk_mode = 2'b00;
        bus.in_valid = 1'b1;
        bus.in_coef  = coefs[6];
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk_idle_outputs("mid_block_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_coefs();
        coefs[2] = 16'sd4;
        coefs[9] = -16'sd6;
        e = model(2'b00, 15);
        chk("pin6_code", e.code, 2);
        chk("pin6_len", e.len, 4);
        send_block(2'b00, 15);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
